dout_arb_ctrl: RTL and testbench

DOUT_ARB_CTRL -- requirements
Module: dout_arb_ctrl

---
 rtl/dout_arb_pkg.sv | 16 +
 rtl/dout_arb_ctrl_rr_grant.sv | 31 +++
 rtl/dout_arb_ctrl.sv | 157 +++++++++++++++
 tb/tb_dout_arb_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dout_arb_pkg.sv
// Shared definitions for the dout_arb_ctrl block: controller state encoding,
// default channel count and the channel-index width used by m_chan.
package dout_arb_pkg;

  localparam int N_CH_DEF = 4;
  localparam int CH_W     = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/dout_arb_ctrl_rr_grant.sv
// Round-robin grant: one-hot grant of the first requesting channel at or
// after the priority pointer, wrapping around. Purely combinational.
module rr_grant
  import dout_arb_pkg::*;
#(
  parameter int N = N_CH_DEF
) (
  input  logic [N-1:0]    req,
  input  logic [CH_W-1:0] ptr,
  output logic [N-1:0]    grant
);

  logic        found;
  int unsigned idx;

  // Scan requesters starting at the pointer and grant the first one found.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dout_arb_ctrl.sv
// dout_arb_ctrl: batches HLS kernel runs (ap_start/ap_done handshake) and
// merges N_CH ap_fifo output streams into one valid/ready stream through a
// single-entry output register with round-robin arbitration.
// Optional feature: define DOUT_ARB_STALL_CNT_EN to add the stall_cnt output.
module dout_arb_ctrl
  import dout_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_CH   = N_CH_DEF,
  parameter int CNT_W  = 6
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic                   ctrl_go,
  input  logic [CNT_W-1:0]       run_target,
  output logic                   ctrl_busy,
  output logic                   ctrl_finished,
  output logic [CNT_W-1:0]       run_cnt,
  output logic                   ap_start,
  input  logic                   ap_done,
  input  logic                   ap_idle,
  input  logic [N_CH*DATA_W-1:0] dout_din,
  input  logic [N_CH-1:0]        dout_write,
  output logic [N_CH-1:0]        dout_full_n,
  output logic [DATA_W-1:0]      m_data,
  output logic [CH_W-1:0]        m_chan,
  output logic                   m_valid,
  input  logic                   m_ready
`ifdef DOUT_ARB_STALL_CNT_EN
  ,
  output logic [31:0]            stall_cnt
`endif
);

  state_t              state;
  logic [CNT_W-1:0]    target;
  logic [CNT_W:0]      next_cnt;
  logic [CH_W-1:0]     ptr;
  logic [N_CH-1:0]     grant;
  logic [CH_W-1:0]     gidx;
  logic [DATA_W-1:0]   sel_data;
  logic                slot_free;
  logic                accept;

  rr_grant #(.N(N_CH)) u_rr_grant (
    .req   (dout_write),
    .ptr   (ptr),
    .grant (grant)
  );

  // The register can take a word when empty or when its word leaves this cycle.
  assign slot_free   = !m_valid || m_ready;
  assign dout_full_n = (ap_rst || !slot_free) ? '0 : grant;
  assign accept      = |(dout_write & dout_full_n);
  assign next_cnt    = {1'b0, run_cnt} + 1'b1;

  // Decode the one-hot grant into a channel index and select its data word.
  always_comb begin
    gidx     = '0;
    sel_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (grant[k]) begin
        gidx     = CH_W'(k);
        sel_data = dout_din[k*DATA_W +: DATA_W];
      end
    end
  end

  // Single-entry output register and round-robin pointer.
  always_ff @(posedge ap_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (ap_rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_chan  <= '0;
      ptr     <= '0;
    end else if (accept) begin
      m_valid <= 1'b1;
      m_data  <= sel_data;
      m_chan  <= gidx;
      ptr     <= (gidx == CH_W'(N_CH - 1)) ? '0 : gidx + 1'b1;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Batch controller FSM with registered handshake and status outputs.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state         <= ST_IDLE;
      target        <= '0;
      run_cnt       <= '0;
      ap_start      <= 1'b0;
      ctrl_busy     <= 1'b0;
      ctrl_finished <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ctrl_go) begin
            target    <= (run_target == '0) ? CNT_W'(1) : run_target;
            run_cnt   <= '0;
            ap_start  <= 1'b1;
            ctrl_busy <= 1'b1;
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (ap_start && !ap_idle) begin
            ap_start <= 1'b0;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (ap_done) begin
            if (run_cnt != '1) run_cnt <= run_cnt + 1'b1;
            if (next_cnt < {1'b0, target}) begin
              ap_start <= 1'b1;
              state    <= ST_START;
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!m_valid) begin
            ctrl_busy     <= 1'b0;
            ctrl_finished <= 1'b1;
            state         <= ST_DONE;
          end
        end
        ST_DONE: begin
          ctrl_finished <= 1'b0;
          state         <= ST_IDLE;
        end
        default: begin
          ap_start      <= 1'b0;
          ctrl_busy     <= 1'b0;
          ctrl_finished <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef DOUT_ARB_STALL_CNT_EN
  // Count back-pressured cycles, saturating; cleared by reset and ctrl_go.
  always_ff @(posedge ap_clk) begin
    if (ap_rst || ctrl_go) begin
      stall_cnt <= '0;
    end else if (m_valid && !m_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dout_arb_ctrl.sv
// Self-checking bench for dout_arb_ctrl: directed stimulus, expected merged
// words pushed to a scoreboard queue and checked by an independent monitor.
module tb_dout_arb_ctrl;
  import dout_arb_pkg::*;

  localparam int DATA_W = 32;
  localparam int N_CH   = 4;
  localparam int CNT_W  = 6;

  logic                   ap_clk;
  logic                   ap_rst;
  logic                   ctrl_go;
  logic [CNT_W-1:0]       run_target;
  logic                   ctrl_busy;
  logic                   ctrl_finished;
  logic [CNT_W-1:0]       run_cnt;
  logic                   ap_start;
  logic                   ap_done;
  logic                   ap_idle;
  logic [N_CH*DATA_W-1:0] dout_din;
  logic [N_CH-1:0]        dout_write;
  logic [N_CH-1:0]        dout_full_n;
  logic [DATA_W-1:0]      m_data;
  logic [1:0]             m_chan;
  logic                   m_valid;
  logic                   m_ready;
`ifdef DOUT_ARB_STALL_CNT_EN
  logic [31:0]            stall_cnt;
`endif

  dout_arb_ctrl #(.DATA_W(DATA_W), .N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .ap_clk        (ap_clk),
    .ap_rst        (ap_rst),
    .ctrl_go       (ctrl_go),
    .run_target    (run_target),
    .ctrl_busy     (ctrl_busy),
    .ctrl_finished (ctrl_finished),
    .run_cnt       (run_cnt),
    .ap_start      (ap_start),
    .ap_done       (ap_done),
    .ap_idle       (ap_idle),
    .dout_din      (dout_din),
    .dout_write    (dout_write),
    .dout_full_n   (dout_full_n),
    .m_data        (m_data),
    .m_chan        (m_chan),
    .m_valid       (m_valid),
    .m_ready       (m_ready)
`ifdef DOUT_ARB_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct packed {
    logic [1:0]  chan;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   fin_cnt = 0;
  int   start_cnt = 0;
  logic start_q = 1'b0;
  logic kern_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: counts finished/ap_start pulses and checks every transferred word.
  initial begin
    exp_t e;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst) begin
        if (ctrl_finished) fin_cnt++;
        if (ap_start && !start_q) start_cnt++;
        if (m_valid && m_ready) begin
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected: got chan %0d data 0x%0h with empty queue", m_chan, m_data);
          end else begin
            e = sb.pop_front();
            check("sb_chan", 64'(m_chan), 64'(e.chan));
            check("sb_data", 64'(m_data), 64'(e.data));
          end
        end
      end
      start_q = ap_start;
    end
  end

  // Kernel model: once started, busy for 50 cycles then pulses ap_done.
  initial begin
    forever begin
      @(negedge ap_clk);
      if (kern_en && ap_start && ap_idle) begin
        @(posedge ap_clk); #1 ap_idle = 1'b0;
        repeat (50) @(posedge ap_clk);
        #1 ap_done = 1'b1;
        @(posedge ap_clk); #1 ap_done = 1'b0;
        ap_idle = 1'b1;
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int pcnt [N_CH];

  task automatic drive_din();
    for (int c = 0; c < N_CH; c++)
      dout_din[c*DATA_W +: DATA_W] = {8'(8'h10 + c), 24'(pcnt[c])};
  endtask

  task automatic wait_run(input string name);
    int cyc = 0;
    while (ap_start !== 1'b0 && cyc < 50) begin
      @(negedge ap_clk);
      cyc++;
    end
    check(name, 64'(cyc < 50), 64'd1);
  endtask

  task automatic run_batch(input logic [CNT_W-1:0] tgt, input int exp_runs);
    int cyc = 0;
    fin_cnt = 0;
    start_cnt = 0;
    run_target = tgt;
    ctrl_go = 1'b1;
    @(posedge ap_clk); #1 ctrl_go = 1'b0;
    @(negedge ap_clk);
    check("batch_busy", 64'(ctrl_busy), 64'd1);
    check("batch_start", 64'(ap_start), 64'd1);
    check("batch_cnt_clr", 64'(run_cnt), 64'd0);
    wait_run("batch_run_timeout");
    // A go pulse mid-batch must be ignored.
    @(posedge ap_clk); #1 run_target = 6'd5; ctrl_go = 1'b1;
    @(posedge ap_clk); #1 ctrl_go = 1'b0;
    while (fin_cnt == 0 && cyc < 1000) begin
      @(negedge ap_clk);
      cyc++;
    end
    check("batch_timeout", 64'(cyc < 1000), 64'd1);
    repeat (5) @(negedge ap_clk);
    check("batch_starts", 64'(start_cnt), 64'(exp_runs));
    check("batch_finished", 64'(fin_cnt), 64'd1);
    check("batch_run_cnt", 64'(run_cnt), 64'(exp_runs));
    check("batch_idle_busy", 64'(ctrl_busy), 64'd0);
  endtask

  initial begin
    logic [N_CH-1:0] acc;
    int accepted;
    int cyc;

    ap_rst = 1'b1;
    ctrl_go = 1'b0;
    run_target = '0;
    ap_done = 1'b0;
    ap_idle = 1'b1;
    dout_din = '1;
    dout_write = '1;
    m_ready = 1'b1;

    // Reset state, with all channels requesting.
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check("rst_ap_start", 64'(ap_start), 64'd0);
    check("rst_busy", 64'(ctrl_busy), 64'd0);
    check("rst_finished", 64'(ctrl_finished), 64'd0);
    check("rst_run_cnt", 64'(run_cnt), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_m_chan", 64'(m_chan), 64'd0);
    check("rst_full_n", 64'(dout_full_n), 64'd0);
    @(posedge ap_clk); #1 ap_rst = 1'b0; dout_write = '0;

    // All channels stream continuously: expect 0,1,2,3,0,... one word per cycle.
    for (int c = 0; c < N_CH; c++) pcnt[c] = 0;
    for (int i = 0; i < 12; i++) sb.push_back({2'(i % 4), 8'(8'h10 + (i % 4)), 24'(i / 4)});
    drive_din();
    dout_write = '1;
    accepted = 0;
    cyc = 0;
    while (accepted < 12 && cyc < 40) begin
      @(negedge ap_clk);
      acc = dout_write & dout_full_n;
      check("stream_onehot", 64'($countones(acc)), 64'd1);
      if (accepted > 0) check("stream_valid", 64'(m_valid), 64'd1);
      @(posedge ap_clk); #1;
      for (int c = 0; c < N_CH; c++) if (acc[c]) pcnt[c]++;
      accepted += $countones(acc);
      cyc++;
      drive_din();
    end
    check("stream_timeout", 64'(accepted >= 12), 64'd1);
    dout_write = '0;
    repeat (2) @(negedge ap_clk);

    // Lone writer on channel 2.
    @(posedge ap_clk); #1;
    dout_din[2*DATA_W +: DATA_W] = 32'hDEADBEEF;
    dout_write = 4'b0100;
    @(negedge ap_clk);
    check("ch2_full_n", 64'(dout_full_n), 64'b0100);
    sb.push_back({2'd2, 32'hDEADBEEF});
    @(posedge ap_clk); #1 dout_write = '0;
    @(negedge ap_clk);
    check("ch2_valid", 64'(m_valid), 64'd1);
    check("ch2_data", 64'(m_data), 64'hDEADBEEF);
    check("ch2_chan", 64'(m_chan), 64'd2);

    // Back-pressure: hold a word for 10 cycles while all channels request.
    @(posedge ap_clk); #1;
    m_ready = 1'b0;
    dout_din[1*DATA_W +: DATA_W] = 32'h12345678;
    dout_write = 4'b0010;
    @(negedge ap_clk);
    check("stall_load_full_n", 64'(dout_full_n), 64'b0010);
    sb.push_back({2'd1, 32'h12345678});
    @(posedge ap_clk); #1 dout_write = '1;
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      check("stall_valid", 64'(m_valid), 64'd1);
      check("stall_data", 64'(m_data), 64'h12345678);
      check("stall_full_n", 64'(dout_full_n), 64'd0);
      @(posedge ap_clk); #1;
    end
`ifdef DOUT_ARB_STALL_CNT_EN
    check("stall_cnt", 64'(stall_cnt), 64'd10);
`endif
    dout_write = '0;
    m_ready = 1'b1;
    repeat (2) @(negedge ap_clk);
    check("stall_released", 64'(m_valid), 64'd0);

    // Batch of two runs, then run_target=0 treated as one run.
    kern_en = 1'b1;
    run_batch(6'd2, 2);
    run_batch(6'd0, 1);

    // Reset in RUN with a held word: word discarded, batch aborted silently.
    @(posedge ap_clk); #1 run_target = 6'd3; ctrl_go = 1'b1;
    @(posedge ap_clk); #1 ctrl_go = 1'b0;
    wait_run("abort_run_timeout");
    @(posedge ap_clk); #1;
    m_ready = 1'b0;
    dout_din[0 +: DATA_W] = 32'hA5A5A5A5;
    dout_write = 4'b0001;
    @(posedge ap_clk); #1 dout_write = '0;
    @(negedge ap_clk);
    check("abort_pre_valid", 64'(m_valid), 64'd1);
    check("abort_pre_busy", 64'(ctrl_busy), 64'd1);
    @(posedge ap_clk); #1 ap_rst = 1'b1;
    @(posedge ap_clk); #1 ap_rst = 1'b0;
    fin_cnt = 0;
    start_cnt = 0;
    @(negedge ap_clk);
    check("abort_m_valid", 64'(m_valid), 64'd0);
    check("abort_busy", 64'(ctrl_busy), 64'd0);
    check("abort_ap_start", 64'(ap_start), 64'd0);
    check("abort_state", 64'(dut.state), 64'(ST_IDLE));
    m_ready = 1'b1;
    repeat (80) @(negedge ap_clk);
    check("abort_no_finished", 64'(fin_cnt), 64'd0);
    check("abort_no_restart", 64'(start_cnt), 64'd0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
